// File: rtl/sgmii_pkg.sv
// Shared definitions for the SGMII/GMII receive path: CRC-32 constants,
// frame status bit positions, receive framer FSM states and preamble/SFD
// byte values, plus a byte-wide reflected CRC-32 step function.
package sgmii_pkg;

  // Reflected Ethernet CRC-32 polynomial, seed and good-frame residue.
  // The residue is the register value left after running the whole frame,
  // FCS included, through the un-inverted CRC.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Bit positions inside the 4-bit per-frame status word.
  localparam int STAT_CRC  = 0;
  localparam int STAT_RXER = 1;
  localparam int STAT_RUNT = 2;
  localparam int STAT_OVER = 3;

  // Preamble and start-of-frame delimiter bytes as seen on GMII.
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Depth of the delay line that hides the trailing FCS from the MAC:
  // one payload byte plus four FCS bytes.
  localparam int DLY_DEPTH = 5;

  // Receive framer states; encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  // One byte of reflected CRC-32, data LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register. Init has priority over enable so that a new
// frame can restart the CRC in the same cycle its SFD is recognised.
module crc32_d8
  import sgmii_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Init,
  input  logic        i_En,
  input  logic [7:0]  i8_Data,
  output logic [31:0] o32_Crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC: reseed, fold in one byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (i_Init) begin
      crc_d = CRC_INIT;
    end else if (i_En) begin
      crc_d = crc32_byte(crc_q, i8_Data);
    end
  end

  // CRC register with synchronous reset to the seed value.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o32_Crc = crc_q;

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delays data by five bytes so the
// FCS never reaches the MAC, and reports CRC, RxER, runt and oversize status
// with the last payload byte. Optional good/bad frame counters are built when
// GMII_RX_STATS_EN is defined.
//
// Handshake: there is no back-pressure. o_Valid is a single-clock pulse that
// qualifies o8_Data; o_Sof/o_Eof only ever assert together with o_Valid, and
// o4_Status is meaningful only while o_Eof is high (zero otherwise).
module gmii_rx_framer
  import sgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Cke,
  input  logic [7:0]  i8_RxD,
  input  logic        i_RxDV,
  input  logic        i_RxER,
  output logic [7:0]  o8_Data,
  output logic        o_Valid,
  output logic        o_Sof,
  output logic        o_Eof,
  output logic [3:0]  o4_Status,
`ifdef GMII_RX_STATS_EN
  output logic [31:0] o32_GoodFrames,
  output logic [31:0] o32_BadFrames,
`endif
  output logic [1:0]  o2_DbgState
);

  localparam logic [10:0] CNT_SAT = 11'(MAX_LEN + 1);
  localparam logic [10:0] CNT_MIN = 11'(MIN_LEN);
  localparam logic [10:0] CNT_MAX = 11'(MAX_LEN);
  localparam logic [2:0]  HELD_FULL = 3'(DLY_DEPTH);

  rx_state_e                   state_q, state_d;
  logic [DLY_DEPTH-1:0][7:0]   line_q, line_d;
  logic [2:0]                  held_q, held_d;
  logic [10:0]                 cnt_q, cnt_d;
  logic                        rxer_q, rxer_d;
  logic                        first_q, first_d;

  logic [7:0]                  data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        sof_q, sof_d;
  logic                        eof_q, eof_d;
  logic [3:0]                  status_q, status_d;

`ifdef GMII_RX_STATS_EN
  logic [31:0]                 good_q, good_d;
  logic [31:0]                 bad_q, bad_d;
`endif

  logic                        sfd_hit;
  logic                        crc_init;
  logic                        crc_en;
  logic [31:0]                 crc_val;
  logic [3:0]                  frame_status;

  crc32_d8 u_crc (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Init  (crc_init),
    .i_En    (crc_en),
    .i8_Data (i8_RxD),
    .o32_Crc (crc_val)
  );

  // Status of the frame that is ending, from the state left by its last byte.
  always_comb begin
    frame_status            = '0;
    frame_status[STAT_CRC]  = (crc_val != CRC_RESIDUE);
    frame_status[STAT_RXER] = rxer_q;
    frame_status[STAT_RUNT] = (cnt_q < CNT_MIN);
    frame_status[STAT_OVER] = (cnt_q > CNT_MAX);
  end

  // Next-state, delay line, counters and output pulses; only strobe cycles
  // move anything, all output pulses default low every clock.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    rxer_d   = rxer_q;
    first_d  = first_q;
    data_d   = '0;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    status_d = '0;
    sfd_hit  = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
`ifdef GMII_RX_STATS_EN
    good_d   = good_q;
    bad_d    = bad_q;
`endif

    if (i_Cke) begin
      unique case (state_q)
        ST_IDLE: begin
          // RxER without DV (false carrier etc.) is deliberately ignored.
          if (i_RxDV) begin
            if (i8_RxD == PREAMBLE_BYTE) begin
              state_d = ST_PREAMBLE;
            end else if (i8_RxD == SFD_BYTE) begin
              sfd_hit = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end
        end

        ST_PREAMBLE: begin
          if (!i_RxDV) begin
            state_d = ST_IDLE;
          end else if (i8_RxD == SFD_BYTE) begin
            sfd_hit = 1'b1;
          end else if (i8_RxD != PREAMBLE_BYTE) begin
            state_d = ST_DROP;
          end
        end

        ST_DATA: begin
          if (i_RxDV) begin
            crc_en = 1'b1;
            line_d = {i8_RxD, line_q[DLY_DEPTH-1:1]};
            if (held_q != HELD_FULL) begin
              held_d = held_q + 3'd1;
            end
            if (cnt_q < CNT_SAT) begin
              cnt_d = cnt_q + 11'd1;
            end
            if (i_RxER) begin
              rxer_d = 1'b1;
            end
            // Line full: the oldest byte cannot be FCS any more, release it.
            if (held_q == HELD_FULL) begin
              valid_d = 1'b1;
              data_d  = line_q[0];
              sof_d   = first_q;
              first_d = 1'b0;
            end
          end else begin
            state_d = ST_IDLE;
            held_d  = '0;
            first_d = 1'b0;
            if (held_q == HELD_FULL) begin
              // line_q[0] is the last payload byte, [4:1] are the FCS.
              valid_d  = 1'b1;
              eof_d    = 1'b1;
              sof_d    = first_q;
              data_d   = line_q[0];
              status_d = frame_status;
`ifdef GMII_RX_STATS_EN
              if (frame_status == 4'b0000) begin
                good_d = good_q + 32'd1;
              end else begin
                bad_d = bad_q + 32'd1;
              end
`endif
            end else begin
              // Fewer than five bytes after SFD: nothing to deliver.
`ifdef GMII_RX_STATS_EN
              bad_d = bad_q + 32'd1;
`endif
            end
          end
        end

        ST_DROP: begin
          if (!i_RxDV) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // SFD starts a fresh frame context whichever state found it.
      if (sfd_hit) begin
        state_d  = ST_DATA;
        crc_init = 1'b1;
        held_d   = '0;
        cnt_d    = '0;
        rxer_d   = 1'b0;
        first_d  = 1'b1;
      end
    end
  end

  // State, delay line, frame context and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      held_q   <= '0;
      cnt_q    <= '0;
      rxer_q   <= 1'b0;
      first_q  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      rxer_q   <= rxer_d;
      first_q  <= first_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      status_q <= status_d;
    end
  end

`ifdef GMII_RX_STATS_EN
  // Frame counters; they wrap naturally at 2^32.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign o32_GoodFrames = good_q;
  assign o32_BadFrames  = bad_q;
`endif

  assign o8_Data     = data_q;
  assign o_Valid     = valid_q;
  assign o_Sof       = sof_q;
  assign o_Eof       = eof_q;
  assign o4_Status   = status_q;
  assign o2_DbgState = state_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: a table of frame records drives full frames and
// pushes the expected payload/Sof/Eof/status per byte into a queue; a negedge
// monitor pops and compares every o_Valid pulse. Hand-written sequences cover
// reset mid-frame, short frames, a bad preamble byte and idle RxER.
module tb_gmii_rx_framer;

  localparam int W = 14; // {data[7:0], sof, eof, status[3:0]}

  logic        clk;
  logic        i_Rst;
  logic        i_Cke;
  logic [7:0]  i8_RxD;
  logic        i_RxDV;
  logic        i_RxER;
  logic [7:0]  o8_Data;
  logic        o_Valid;
  logic        o_Sof;
  logic        o_Eof;
  logic [3:0]  o4_Status;
  logic [1:0]  o2_DbgState;
`ifdef GMII_RX_STATS_EN
  logic [31:0] o32_GoodFrames;
  logic [31:0] o32_BadFrames;
  int          exp_good;
  int          exp_bad;
`endif

  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_miss;

  typedef struct {
    int         plen;
    int         pre_n;
    int         flip;
    int         rxer_at;
    int         div;
    int         gap;
    logic [3:0] st;
  } vec_t;

  vec_t tbl[11];

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .i_Clk          (clk),
    .i_Rst          (i_Rst),
    .i_Cke          (i_Cke),
    .i8_RxD         (i8_RxD),
    .i_RxDV         (i_RxDV),
    .i_RxER         (i_RxER),
    .o8_Data        (o8_Data),
    .o_Valid        (o_Valid),
    .o_Sof          (o_Sof),
    .o_Eof          (o_Eof),
    .o4_Status      (o4_Status),
`ifdef GMII_RX_STATS_EN
    .o32_GoodFrames (o32_GoodFrames),
    .o32_BadFrames  (o32_BadFrames),
`endif
    .o2_DbgState    (o2_DbgState)
  );

  // Clock and safety timeout.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete, got running, required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Bench-side reference CRC step (reflected Ethernet CRC-32).
  function automatic logic [31:0] ref_crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // One byte on the wire; div>1 inserts div-1 non-strobe clocks first.
  task automatic strobe(input logic dv, input logic [7:0] d, input logic er, input int div);
    i_RxDV = dv;
    i8_RxD = d;
    i_RxER = er;
    for (int k = 0; k < div - 1; k++) begin
      i_Cke = 1'b0;
      @(posedge clk); #1;
    end
    i_Cke = 1'b1;
    @(posedge clk); #1;
    if (div > 1) i_Cke = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Full frame: preamble, SFD, payload, FCS, DV=0, then gap strobes.
  task automatic send_frame(input vec_t v);
    logic [7:0]  fr[0:1535];
    logic [31:0] c;
    int          n;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < v.plen; i++) begin
      fr[i] = 8'($urandom_range(0, 255));
      c = ref_crc_step(c, fr[i]);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) fr[v.plen + j] = c[8*j +: 8];
    if (v.flip >= 0) fr[v.flip] = fr[v.flip] ^ 8'h04;
    n = v.plen + 4;
    for (int i = 0; i < v.plen; i++) begin
      exp_q.push_back({fr[i], (i == 0), (i == v.plen - 1),
                       (i == v.plen - 1) ? v.st : 4'b0000});
    end
`ifdef GMII_RX_STATS_EN
    if (v.st == 4'b0000) exp_good++;
    else exp_bad++;
`endif
    for (int p = 0; p < v.pre_n; p++) strobe(1'b1, 8'h55, 1'b0, v.div);
    strobe(1'b1, 8'hD5, 1'b0, v.div);
    for (int i = 0; i < n; i++) strobe(1'b1, fr[i], (i == v.rxer_at), v.div);
    strobe(1'b0, 8'h00, 1'b0, v.div);
    check("eof_latency", {31'd0, o_Eof}, 32'd1);
    if (v.gap > 0) begin
      @(posedge clk); #1;
      check("eof_pulse_width", {31'd0, o_Eof}, 32'd0);
      for (int g = 1; g < v.gap; g++) strobe(1'b0, 8'h00, 1'b0, v.div);
      drain("frame_drained");
`ifdef GMII_RX_STATS_EN
      check("good_count", o32_GoodFrames, exp_good);
      check("bad_count", o32_BadFrames, exp_bad);
`endif
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (o_Valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: got data=%h sof=%b eof=%b st=%b, required no output",
                 o8_Data, o_Sof, o_Eof, o4_Status);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", {18'd0, o8_Data, o_Sof, o_Eof, o4_Status}, {18'd0, e});
      end
    end else if (o_Sof || o_Eof) begin
      n_vec++;
      n_miss++;
      $display("FAIL stray_marker: got sof=%b eof=%b, required 0 without valid", o_Sof, o_Eof);
    end
  end

  initial begin
    logic [7:0] fr[0:31];
    vec_t       v;
    n_vec  = 0;
    n_miss = 0;
`ifdef GMII_RX_STATS_EN
    exp_good = 0;
    exp_bad  = 0;
`endif
    //            plen pre flip rxer div gap status
    tbl[0]  = '{60,   7, -1, -1,  1, 3, 4'b0000}; // 64-byte good
    tbl[1]  = '{60,   7,  2, -1,  1, 3, 4'b0001}; // bit flip -> CRC error
    tbl[2]  = '{36,   7, -1, -1,  1, 3, 4'b0100}; // 40 bytes -> runt
    tbl[3]  = '{59,   7, -1, -1,  1, 3, 4'b0100}; // 63 bytes -> runt
    tbl[4]  = '{1514, 7, -1, -1,  1, 3, 4'b0000}; // 1518 bytes -> good
    tbl[5]  = '{1518, 7, -1, -1,  1, 3, 4'b1000}; // 1522 bytes -> oversize
    tbl[6]  = '{60,   7, -1, 20,  1, 3, 4'b0010}; // RxER mid payload
    tbl[7]  = '{60,   7, -1, -1, 10, 3, 4'b0000}; // 100M byte strobe
    tbl[8]  = '{1,    7, -1, -1,  1, 3, 4'b0100}; // 5 bytes: Sof+Eof together
    tbl[9]  = '{60,   0, -1, -1,  1, 0, 4'b0000}; // SFD only, then back-to-back
    tbl[10] = '{60,   3, -1, -1,  1, 3, 4'b0000}; // follows a single DV=0 gap

    // Reset block and reset-state checks.
    i_Rst = 1'b1; i_Cke = 1'b1; i_RxDV = 1'b0; i8_RxD = 8'h00; i_RxER = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, o_Valid}, 32'd0);
    check("rst_sof_eof", {30'd0, o_Sof, o_Eof}, 32'd0);
    check("rst_status", {28'd0, o4_Status}, 32'd0);
    check("rst_data", {24'd0, o8_Data}, 32'd0);
    check("rst_state", {30'd0, o2_DbgState}, 32'd0);
`ifdef GMII_RX_STATS_EN
    check("rst_good", o32_GoodFrames, 32'd0);
    check("rst_bad", o32_BadFrames, 32'd0);
`endif
    i_Rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames.
    for (int t = 0; t < 11; t++) send_frame(tbl[t]);

    // RxER with DV low between frames must not taint the next frame.
    for (int k = 0; k < 3; k++) strobe(1'b0, 8'h00, 1'b1, 1);
    send_frame(tbl[0]);

    // Reset at byte 30: bytes 0..24 already out, rest discarded, DROP after.
    for (int i = 0; i < 30; i++) begin
      fr[i] = 8'($urandom_range(0, 255));
      if (i < 25) exp_q.push_back({fr[i], (i == 0), 1'b0, 4'b0000});
    end
    for (int p = 0; p < 7; p++) strobe(1'b1, 8'h55, 1'b0, 1);
    strobe(1'b1, 8'hD5, 1'b0, 1);
    for (int i = 0; i < 30; i++) strobe(1'b1, fr[i], 1'b0, 1);
    i_Rst = 1'b1; i_RxDV = 1'b1; i8_RxD = 8'h3C;
    @(posedge clk); #1;
    i_Rst = 1'b0;
    check("mid_rst_valid", {31'd0, o_Valid}, 32'd0);
    strobe(1'b1, 8'h3C, 1'b0, 1);
    check("mid_rst_drop", {30'd0, o2_DbgState}, 32'd3);
    for (int k = 0; k < 20; k++) strobe(1'b1, 8'h3C, 1'b0, 1);
    strobe(1'b0, 8'h00, 1'b0, 1);
    check("mid_rst_idle", {30'd0, o2_DbgState}, 32'd0);
    drain("mid_rst_drained");
`ifdef GMII_RX_STATS_EN
    exp_good = 0;
    exp_bad  = 0;
    check("mid_rst_good", o32_GoodFrames, exp_good);
    check("mid_rst_bad", o32_BadFrames, exp_bad);
`endif
    send_frame(tbl[0]);

    // Three bytes after SFD: no output, counted bad.
    for (int p = 0; p < 7; p++) strobe(1'b1, 8'h55, 1'b0, 1);
    strobe(1'b1, 8'hD5, 1'b0, 1);
    for (int i = 0; i < 3; i++) strobe(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1);
    strobe(1'b0, 8'h00, 1'b0, 1);
    repeat (3) strobe(1'b0, 8'h00, 1'b0, 1);
`ifdef GMII_RX_STATS_EN
    exp_bad++;
    check("short_good", o32_GoodFrames, exp_good);
    check("short_bad", o32_BadFrames, exp_bad);
`endif

    // Corrupt preamble byte 0x5F: DROP until DV falls, nothing emitted.
    for (int p = 0; p < 3; p++) strobe(1'b1, 8'h55, 1'b0, 1);
    strobe(1'b1, 8'h5F, 1'b0, 1);
    check("bad_pre_drop", {30'd0, o2_DbgState}, 32'd3);
    strobe(1'b1, 8'hD5, 1'b0, 1);
    for (int k = 0; k < 20; k++) strobe(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1);
    strobe(1'b0, 8'h00, 1'b0, 1);
    check("bad_pre_idle", {30'd0, o2_DbgState}, 32'd0);
    repeat (3) strobe(1'b0, 8'h00, 1'b0, 1);
    check("bad_pre_no_output", exp_q.size(), 0);
`ifdef GMII_RX_STATS_EN
    check("bad_pre_good", o32_GoodFrames, exp_good);
    check("bad_pre_bad", o32_BadFrames, exp_bad);
`endif

    // One more good frame to confirm recovery.
    v = tbl[0];
    send_frame(v);
    drain("final_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gmii_rx_framer.md
# gmii_rx_framer

GMII receive framer that sits directly downstream of the SGMII PCS receive path on the MAC side. It consumes the `o8_RxD`/`o_RxDV`/`o_RxER` byte stream and strips preamble and SFD. It checks FCS (CRC-32), frame length and RxER, then delivers payload bytes with start/end markers and a per-frame status word to the MAC receive logic.

## Interface
- `MIN_LEN`, default 64: minimum legal frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, default 1518: maximum legal frame length in bytes, DA through FCS inclusive.

Ports:
- `i_Clk` in 1: GMII clock (125 MHz).
- `i_Rst` in 1: reset, synchronous, active-high.
- `i_Cke` in 1: byte strobe. Tie high at 1000M; one pulse per byte at 10/100M.
- `i8_RxD` in 8: GMII receive data.
- `i_RxDV` in 1: GMII receive data valid.
- `i_RxER` in 1: GMII receive error.
- `o8_Data` out 8: payload byte, FCS excluded.
- `o_Valid` out 1: `o8_Data` valid.
- `o_Sof` out 1: first payload byte of the frame.
- `o_Eof` out 1: last payload byte of the frame; `o4_Status` valid with it.
- `o4_Status` out 4: bit0 CRC error, bit1 RxER seen, bit2 runt, bit3 oversize. All zero means a good frame.
- `o32_GoodFrames` out 32: present only with `GMII_RX_STATS_EN`.
- `o32_BadFrames` out 32: present only with `GMII_RX_STATS_EN`.

## Operation
- State advances only on cycles with `i_Cke`=1.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: DV=1 and byte 0x55 goes to PREAMBLE. DV=1 and byte 0xD5 goes to DATA (short preamble accepted). DV=1 with any other byte goes to DROP. RxER in IDLE is ignored.
  - PREAMBLE: 0x55 stays; any number of 0x55 bytes is accepted. 0xD5 goes to DATA. Any other byte goes to DROP. DV=0 goes to IDLE.
  - DATA: each byte enters a 5-deep delay line, the CRC and the byte counter. DV=0 ends the frame and returns to IDLE.
  - DROP: wait for DV=0, then go to IDLE. Nothing is emitted or counted.
- Delay line:
  - Once 5 bytes are held, each new byte pushes the oldest out on `o8_Data` with `o_Valid`.
  - `o_Sof` marks the first byte emitted in a frame.
  - At frame end the line holds the last payload byte plus 4 FCS bytes. The last payload byte is emitted with `o_Eof` and `o4_Status`, and the FCS bytes are discarded.
  - A frame with fewer than 5 bytes after SFD emits nothing and is counted bad.
- CRC: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, computed over all bytes after SFD including FCS. The frame is good only if the register equals 0xDEBB20E3 after the final byte.
- Byte counter: 11 bits, saturates at `MAX_LEN`+1. Runt if count < `MIN_LEN`; oversize if count > `MAX_LEN`. Oversize frames are still delivered, flagged.
- RxER: sets a sticky flag while in DATA; the flag clears on SFD.

## Timing
- Outputs are registered. `o_Valid`/`o_Sof`/`o_Eof` are one-`i_Clk` pulses, in the cycle after the `i_Cke` cycle that caused them.
- Byte k of a frame is emitted one clock after the strobe cycle that samples byte k+5.
- `o_Eof` is emitted one clock after the strobe cycle that samples DV=0.
- 5-byte frame: `o_Sof` and `o_Eof` assert in the same cycle.
- Back-to-back frames with a single DV=0 gap are supported. The Eof of frame N precedes the Sof of frame N+1.
- Reset values: all outputs 0, counters 0, FSM IDLE.
- `i_Rst` mid-frame: partial frame discarded with no Eof and no count. If DV is still high after reset, the FSM sees a non-preamble byte, enters DROP and waits for DV=0.

## Configuration
- `GMII_RX_STATS_EN` defined:
  - `o32_GoodFrames` increments on Eof with status 0.
  - `o32_BadFrames` increments on Eof with nonzero status, and on short frames (<5 bytes).
  - Both counters wrap at 2^32 and clear on `i_Rst`.
- Not defined: both ports and the counters are absent.

## Structure
- Shared package `sgmii_pkg`: CRC polynomial, init and residue constants; status bit indices; FSM state enum; preamble/SFD byte constants.
- Sub-module `crc32_d8`: byte-wide CRC-32 update with synchronous init and enable.

## Test plan
- 64-byte frame (60 payload bytes + correct FCS), 7×0x55 + 0xD5 preamble, `i_Cke`=1: 60 `o_Valid` pulses, `o_Sof` on the 1st, `o_Eof` on the 60th, `o4_Status`=0000. Good count +1.
- Same frame with one payload bit flipped: `o4_Status`=0001. Bad count +1.
- 40-byte frame with valid FCS: `o4_Status`=0100. 1522-byte frame: `o4_Status`=1000 and all 1518 payload bytes delivered.
- RxER pulsed mid-payload: `o4_Status` bit1 set. RxER with DV=0 between frames: no effect.
- Byte strobe `i_Cke` every 10 clocks (100M): identical output sequence. Pulses last 1 clock. `i_Rst` asserted at byte 30: no Eof, no count, and the next frame is received correctly.
- 3-byte frame after SFD: no outputs, bad count +1. Preamble byte 0x5F: DROP, no outputs, no counts.
